vertex_xform_pipe: RTL and testbench

- Parametrised, fully pipelined successor to the single-vertex graphics-pipeline transform path.
- Per vertex: scale, yaw/pitch/roll rotation, translation, camera offset and viewport scaling by camDc.
- Generalised over data width and fixed-point format; adds valid/ready flow control, a tag passthrough, per-vertex exception flags, and a drain-then-load configuration FSM.
- Sits between the vertex fetch stage and the rasteriser.

---
 rtl/vertex_xform_pipe.sv | 224 ++++++++++++++++++++++
 tb/tb_vertex_xform_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_xform_pipe.sv
// vertex_xform_pipe: six-stage fixed-point vertex transform (scale, yaw/pitch/roll, translate, viewport)
// with valid/ready flow control and a drain-then-load config FSM. Macro VXP_CLIP_EN enables z<=0 drop + drop_cnt.
module vertex_xform_pipe #(
    parameter int unsigned W        = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned VIEW_LIM = 16'h7000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    output logic             cfg_busy,
    input  logic [W-1:0]     camVerX,
    input  logic [W-1:0]     camVerY,
    input  logic [W-1:0]     camVerZ,
    input  logic [W-1:0]     camDc,
    input  logic [W-1:0]     cosRoll,
    input  logic [W-1:0]     cosPitch,
    input  logic [W-1:0]     cosYaw,
    input  logic [W-1:0]     senRoll,
    input  logic [W-1:0]     senPitch,
    input  logic [W-1:0]     senYaw,
    input  logic [W-1:0]     scaleX,
    input  logic [W-1:0]     scaleY,
    input  logic [W-1:0]     scaleZ,
    input  logic [W-1:0]     transX,
    input  logic [W-1:0]     transY,
    input  logic [W-1:0]     transZ,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     vertexX,
    input  logic [W-1:0]     vertexY,
    input  logic [W-1:0]     vertexZ,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     outX,
    output logic [W-1:0]     outY,
    output logic [W-1:0]     outZ,
    output logic [3:0]       outException,
`ifdef VXP_CLIP_EN
    output logic [15:0]      drop_cnt,
`endif
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PW = 2 * W + 1;

    typedef logic signed [W-1:0]  sw_t;
    typedef logic signed [PW-1:0] sp_t;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_LOAD} state_t;

    localparam sp_t SMAX = (sp_t'(1) <<< (W - 1)) - sp_t'(1);
    localparam sp_t SMIN = -(sp_t'(1) <<< (W - 1));
    localparam sp_t RND  = sp_t'(1) <<< (FRAC - 1);

    function automatic sp_t mul(input sw_t a, input sw_t b);
        sp_t ea;
        sp_t eb;
        ea = PW'(a);
        eb = PW'(b);
        return ea * eb;
    endfunction

    // Returns {saturated, value[W-1:0]}
    function automatic logic [W:0] sat(input sp_t a);
        if (a > SMAX) return {1'b1, W'(SMAX)};
        if (a < SMIN) return {1'b1, W'(SMIN)};
        return {1'b0, a[W-1:0]};
    endfunction

    function automatic logic [W:0] rnd_sat(input sp_t s);
        sp_t t;
        t = (s + RND) >>> FRAC;
        return sat(t);
    endfunction

    function automatic logic over_lim(input sw_t v);
        logic [W:0] mag;
        mag = v[W-1] ? ((W+1)'(~v) + (W+1)'(1)) : (W+1)'(v);
        return mag > (W+1)'(VIEW_LIM);
    endfunction

    state_t r_state, w_state_nxt;
    logic   w_busy_nxt;
    logic   w_adv, w_acc, w_any_valid, w_zle;

    sw_t r_cx, r_cy_cam, r_cz, r_dc, r_cr, r_cp, r_cy, r_sr, r_sp, r_sy;
    sw_t r_scx, r_scy, r_scz, r_tx, r_ty, r_tz;

    sw_t r_x0, r_y0, r_z0, r_x1, r_y1, r_z1, r_x2, r_y2, r_z2;
    sw_t r_x3, r_y3, r_z3, r_x4, r_y4, r_z4;
    logic [TAG_W-1:0] r_t0, r_t1, r_t2, r_t3, r_t4;
    logic r_v0, r_v1, r_v2, r_v3, r_v4;
    logic r_s0, r_s1, r_s2, r_s3, r_s4;

    logic [W:0] w_s0x, w_s0y, w_s0z, w_s1x, w_s1y, w_s2x, w_s2z;
    logic [W:0] w_s3y, w_s3z, w_s4x, w_s4y, w_s4z, w_s5x, w_s5y;
    logic signed [W+1:0] w_c4x, w_c4y, w_c4z;

    assign w_adv       = !out_valid || out_ready;
    assign in_ready    = w_adv && (r_state == ST_RUN) && !cfg_load;
    assign w_acc       = in_valid && in_ready;
    assign w_any_valid = r_v0 | r_v1 | r_v2 | r_v3 | r_v4 | out_valid;
    assign w_zle       = r_z4[W-1] || (r_z4 == '0);

    assign w_s0x = rnd_sat(mul(vertexX, r_scx));
    assign w_s0y = rnd_sat(mul(vertexY, r_scy));
    assign w_s0z = rnd_sat(mul(vertexZ, r_scz));
    assign w_s1x = rnd_sat(mul(r_x0, r_cy) - mul(r_y0, r_sy));
    assign w_s1y = rnd_sat(mul(r_x0, r_sy) + mul(r_y0, r_cy));
    assign w_s2x = rnd_sat(mul(r_x1, r_cp) + mul(r_z1, r_sp));
    assign w_s2z = rnd_sat(mul(r_z1, r_cp) - mul(r_x1, r_sp));
    assign w_s3y = rnd_sat(mul(r_y2, r_cr) - mul(r_z2, r_sr));
    assign w_s3z = rnd_sat(mul(r_y2, r_sr) + mul(r_z2, r_cr));

    // Translate minus camera at W+2 bits so the sum cannot wrap before saturation
    assign w_c4x = (W+2)'(r_x3) + (W+2)'(r_tx) - (W+2)'(r_cx);
    assign w_c4y = (W+2)'(r_y3) + (W+2)'(r_ty) - (W+2)'(r_cy_cam);
    assign w_c4z = (W+2)'(r_z3) + (W+2)'(r_tz) - (W+2)'(r_cz);
    assign w_s4x = sat(PW'(w_c4x));
    assign w_s4y = sat(PW'(w_c4y));
    assign w_s4z = sat(PW'(w_c4z));
    assign w_s5x = rnd_sat(mul(r_x4, r_dc));
    assign w_s5y = rnd_sat(mul(r_y4, r_dc));

    // Config FSM next state
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = cfg_busy;
        case (r_state)
            ST_RUN: if (cfg_load) begin
                w_state_nxt = ST_DRAIN;
                w_busy_nxt  = 1'b1;
            end
            ST_DRAIN: if (!w_any_valid) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_state_nxt = ST_RUN;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            cfg_busy <= 1'b0;
            r_cx <= '0; r_cy_cam <= '0; r_cz <= '0; r_dc <= '0;
            r_cr <= '0; r_cp <= '0; r_cy <= '0; r_sr <= '0; r_sp <= '0; r_sy <= '0;
            r_scx <= '0; r_scy <= '0; r_scz <= '0; r_tx <= '0; r_ty <= '0; r_tz <= '0;
        end else begin
            r_state  <= w_state_nxt;
            cfg_busy <= w_busy_nxt;
            if (r_state == ST_LOAD) begin
                r_cx <= camVerX; r_cy_cam <= camVerY; r_cz <= camVerZ; r_dc <= camDc;
                r_cr <= cosRoll; r_cp <= cosPitch; r_cy <= cosYaw;
                r_sr <= senRoll; r_sp <= senPitch; r_sy <= senYaw;
                r_scx <= scaleX; r_scy <= scaleY; r_scz <= scaleZ;
                r_tx <= transX; r_ty <= transY; r_tz <= transZ;
            end
        end
    end

    // Pipeline stages; everything advances together under the global stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0; r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
            r_s0 <= 1'b0; r_s1 <= 1'b0; r_s2 <= 1'b0; r_s3 <= 1'b0; r_s4 <= 1'b0;
            r_x0 <= '0; r_y0 <= '0; r_z0 <= '0; r_x1 <= '0; r_y1 <= '0; r_z1 <= '0;
            r_x2 <= '0; r_y2 <= '0; r_z2 <= '0; r_x3 <= '0; r_y3 <= '0; r_z3 <= '0;
            r_x4 <= '0; r_y4 <= '0; r_z4 <= '0;
            r_t0 <= '0; r_t1 <= '0; r_t2 <= '0; r_t3 <= '0; r_t4 <= '0;
            out_valid    <= 1'b0;
            outX         <= '0;
            outY         <= '0;
            outZ         <= '0;
            outException <= '0;
            out_tag      <= '0;
`ifdef VXP_CLIP_EN
            drop_cnt     <= '0;
`endif
        end else if (w_adv) begin
            r_v0 <= w_acc;
            r_x0 <= w_s0x[W-1:0]; r_y0 <= w_s0y[W-1:0]; r_z0 <= w_s0z[W-1:0];
            r_s0 <= w_s0x[W] | w_s0y[W] | w_s0z[W];
            r_t0 <= in_tag;

            r_v1 <= r_v0;
            r_x1 <= w_s1x[W-1:0]; r_y1 <= w_s1y[W-1:0]; r_z1 <= r_z0;
            r_s1 <= r_s0 | w_s1x[W] | w_s1y[W];
            r_t1 <= r_t0;

            r_v2 <= r_v1;
            r_x2 <= w_s2x[W-1:0]; r_y2 <= r_y1; r_z2 <= w_s2z[W-1:0];
            r_s2 <= r_s1 | w_s2x[W] | w_s2z[W];
            r_t2 <= r_t1;

            r_v3 <= r_v2;
            r_x3 <= r_x2; r_y3 <= w_s3y[W-1:0]; r_z3 <= w_s3z[W-1:0];
            r_s3 <= r_s2 | w_s3y[W] | w_s3z[W];
            r_t3 <= r_t2;

            r_v4 <= r_v3;
            r_x4 <= w_s4x[W-1:0]; r_y4 <= w_s4y[W-1:0]; r_z4 <= w_s4z[W-1:0];
            r_s4 <= r_s3 | w_s4x[W] | w_s4y[W] | w_s4z[W];
            r_t4 <= r_t3;

            outX         <= w_s5x[W-1:0];
            outY         <= w_s5y[W-1:0];
            outZ         <= r_z4;
            outException <= {1'b0, over_lim(w_s5x[W-1:0]) | over_lim(w_s5y[W-1:0]), w_zle,
                             r_s4 | w_s5x[W] | w_s5y[W]};
            out_tag      <= r_t4;
`ifdef VXP_CLIP_EN
            out_valid    <= r_v4 && !w_zle;
            if (r_v4 && w_zle && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
`else
            out_valid    <= r_v4;
`endif
        end
    end

endmodule

// File: tb/tb_vertex_xform_pipe.sv
// Self-checking bench for vertex_xform_pipe: directed steps, scoreboard queue, reference model.
module tb_vertex_xform_pipe;

    localparam int unsigned W = 16;
`ifdef VXP_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [3:0]  exc;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, cfg_load, cfg_busy, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] camVerX, camVerY, camVerZ, camDc;
    logic [15:0] cosRoll, cosPitch, cosYaw, senRoll, senPitch, senYaw;
    logic [15:0] scaleX, scaleY, scaleZ, transX, transY, transZ;
    logic [15:0] vertexX, vertexY, vertexZ, outX, outY, outZ;
    logic [7:0]  in_tag, out_tag;
    logic [3:0]  outException;
`ifdef VXP_CLIP_EN
    logic [15:0] drop_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];
    bit   m_sat;
    bit   rdy_mode = 1'b0;
    logic [3:0] pat = 4'b1001;
    bit   h_act = 1'b0;
    logic [63:0] h_val;

    vertex_xform_pipe dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
        .camVerX(camVerX), .camVerY(camVerY), .camVerZ(camVerZ), .camDc(camDc),
        .cosRoll(cosRoll), .cosPitch(cosPitch), .cosYaw(cosYaw),
        .senRoll(senRoll), .senPitch(senPitch), .senYaw(senYaw),
        .scaleX(scaleX), .scaleY(scaleY), .scaleZ(scaleZ),
        .transX(transX), .transY(transY), .transZ(transZ),
        .in_valid(in_valid), .in_ready(in_ready),
        .vertexX(vertexX), .vertexY(vertexY), .vertexZ(vertexZ), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .outX(outX), .outY(outY), .outZ(outZ), .outException(outException),
`ifdef VXP_CLIP_EN
        .drop_cnt(drop_cnt),
`endif
        .out_tag(out_tag)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint clp(input longint t);
        if (t > 32767) begin m_sat = 1'b1; return 32767; end
        if (t < -32768) begin m_sat = 1'b1; return -32768; end
        return t;
    endfunction

    function automatic longint fx(input longint s);
        return clp((s + 128) >>> 8);
    endfunction

    // Reference model from the arithmetic description, using the config currently on the ports
    function automatic exp_t model(input logic [15:0] vx, vy, vz, input logic [7:0] tg);
        longint x, y, z, x1, y1, x2, z2, y3, z3, xc, yc, zc, ox, oy;
        exp_t e;
        m_sat = 1'b0;
        x  = fx(sx(vx) * sx(scaleX));
        y  = fx(sx(vy) * sx(scaleY));
        z  = fx(sx(vz) * sx(scaleZ));
        x1 = fx(x * sx(cosYaw) - y * sx(senYaw));
        y1 = fx(x * sx(senYaw) + y * sx(cosYaw));
        x2 = fx(x1 * sx(cosPitch) + z * sx(senPitch));
        z2 = fx(-x1 * sx(senPitch) + z * sx(cosPitch));
        y3 = fx(y1 * sx(cosRoll) - z2 * sx(senRoll));
        z3 = fx(y1 * sx(senRoll) + z2 * sx(cosRoll));
        xc = clp(x2 + sx(transX) - sx(camVerX));
        yc = clp(y3 + sx(transY) - sx(camVerY));
        zc = clp(z3 + sx(transZ) - sx(camVerZ));
        ox = fx(xc * sx(camDc));
        oy = fx(yc * sx(camDc));
        e.x   = 16'(ox);
        e.y   = 16'(oy);
        e.z   = 16'(zc);
        e.exc = {1'b0, (ox > 28672 || ox < -28672 || oy > 28672 || oy < -28672), (zc <= 0), m_sat};
        e.tag = tg;
        return e;
    endfunction

    task automatic cfg_identity();
        camVerX = 0; camVerY = 0; camVerZ = 0; camDc = 256;
        cosRoll = 256; cosPitch = 256; cosYaw = 256;
        senRoll = 0; senPitch = 0; senYaw = 0;
        scaleX = 256; scaleY = 256; scaleZ = 256;
        transX = 0; transY = 0; transZ = 0;
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        @(negedge clk);
        chk("load_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("load_busy_set", 64'(cfg_busy), 64'd1);
        for (int n = 0; n < 100 && cfg_busy; n++) begin
            @(posedge clk); #1;
        end
        chk("load_busy_clear", 64'(cfg_busy), 64'd0);
    endtask

    task automatic send(input logic [15:0] vx, vy, vz, input logic [7:0] tg,
                        input bit use_model, input exp_t e_in);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        vertexX = vx; vertexY = vy; vertexZ = vz; in_tag = tg; in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                e = use_model ? model(vx, vy, vz, tg) : e_in;
                if (!(CLIP && e.exc[1])) q.push_back(e);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 400 && (q.size() != 0 || out_valid); n++) @(negedge clk);
        chk("drain_queue", 64'(q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: always 1, or the repeating 1,0,0,1 pattern
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                out_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard pop and hold-stability check
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (h_act)
                chk("hold_stable", {3'b0, out_valid, outX, outY, outZ, outException, out_tag}, h_val);
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("outX", 64'(outX), 64'(e.x));
                    chk("outY", 64'(outY), 64'(e.y));
                    chk("outZ", 64'(outZ), 64'(e.z));
                    chk("exc", 64'(outException), 64'(e.exc));
                    chk("tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end
        h_act = out_valid && !out_ready && !rst;
        h_val = {3'b0, 1'b1, outX, outY, outZ, outException, out_tag};
    end

    initial begin
        int   lat;
        int   seen;
        exp_t e;
        e = '0;
        rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0;
        vertexX = 0; vertexY = 0; vertexZ = 0; in_tag = 0;
        cfg_identity();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_outX", 64'(outX), 64'd0);
        chk("rst_exc", 64'(outException), 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Identity transform and latency
        do_load();
        send(16'd512, 16'hFF00, 16'd1024, 8'h5A, 1'b0, {16'd512, 16'hFF00, 16'd1024, 4'b0000, 8'h5A});
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        chk("latency", 64'(lat), 64'd6);
        wait_drain();

        // Yaw 90 degrees
        cosYaw = 0; senYaw = 256;
        do_load();
        send(16'd256, 16'd0, 16'd256, 8'h11, 1'b0, {16'd0, 16'd256, 16'd256, 4'b0000, 8'h11});
        wait_drain();

        // Saturation + viewport, then z<=0
        cfg_identity(); scaleX = 16'h7FFF;
        do_load();
        send(16'h7FFF, 16'd0, 16'd256, 8'h22, 1'b0, {16'h7FFF, 16'd0, 16'd256, 4'b0101, 8'h22});
        send(16'd0, 16'd0, 16'hFF00, 8'h33, 1'b0, {16'd0, 16'd0, 16'hFF00, 4'b0010, 8'h33});
        wait_drain();
        repeat (4) @(posedge clk);
`ifdef VXP_CLIP_EN
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
`endif

        // Stream with out_ready 1,0,0,1; viewport boundaries first
        cfg_identity();
        do_load();
        rdy_mode = 1'b1;
        send(16'h7000, 16'd0, 16'd256, 8'd0, 1'b0, {16'h7000, 16'd0, 16'd256, 4'b0000, 8'd0});
        send(16'h7001, 16'd0, 16'd256, 8'd1, 1'b0, {16'h7001, 16'd0, 16'd256, 4'b0100, 8'd1});
        send(16'h9000, 16'd0, 16'd256, 8'd2, 1'b0, {16'h9000, 16'd0, 16'd256, 4'b0000, 8'd2});
        send(16'h8FFF, 16'd0, 16'd256, 8'd3, 1'b0, {16'h8FFF, 16'd0, 16'd256, 4'b0100, 8'd3});
        for (int i = 4; i < 10; i++)
            send(16'($urandom), 16'($urandom), 16'($urandom), 8'(i), 1'b1, e);
        wait_drain();
        rdy_mode = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Config change mid-stream: first 3 use old config, last 3 the new one
        for (int i = 0; i < 3; i++)
            send(16'(100 * i + 50), 16'(300 - 40 * i), 16'(200 + i), 8'(8'h40 + i), 1'b1, e);
        cosYaw = 0; senYaw = 256; transX = 100; camVerY = 50; camDc = 512;
        vertexX = 16'd70; vertexY = 16'd90; vertexZ = 16'd500; in_tag = 8'h43;
        in_valid = 1'b1; cfg_load = 1'b1;
        @(negedge clk);
        chk("cfg_same_cycle_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("cfg_busy_set", 64'(cfg_busy), 64'd1);
        for (int n = 0; n < 60 && cfg_busy; n++) begin
            @(negedge clk);
            chk("cfg_drain_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("cfg_busy_clear", 64'(cfg_busy), 64'd0);
        chk("cfg_old_drained", 64'(q.size()), 64'd0);
        for (int i = 3; i < 6; i++)
            send(16'(70 + 11 * i), 16'(90 - 7 * i), 16'(500 + 3 * i), 8'(8'h40 + i), 1'b1, e);
        wait_drain();

        // Reset with 4 vertices in flight
        for (int i = 0; i < 4; i++)
            send(16'(10 * i), 16'(20 * i), 16'(300), 8'(8'h70 + i), 1'b1, e);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(cfg_busy), 64'd0);
`ifdef VXP_CLIP_EN
        chk("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        seen = n_out;
        repeat (12) @(posedge clk);
        #1;
        chk("no_flushed_output", 64'(n_out - seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
